// File: rtl/pipe_skid_reg_pkg.sv
// Shared definitions for the pipe_skid_reg block: default widths, the
// occupancy-state encoding, and the reset/stall polarity constants.
package pipe_skid_reg_pkg;

   // Default field and counter widths.
   localparam int DEF_PC_W   = 32;
   localparam int DEF_INST_W = 32;
   localparam int DEF_SIDE_W = 8;
   localparam int DEF_CNT_W  = 16;

   // Reset is active-high.
   localparam logic RST_ENABLE = 1'b1;

   // Back-pressure indication used to drive the stall counter.
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // Buffer occupancy: EMPTY = 0 entries, ONE = 1 entry, FULL = 2 entries.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_sat_cnt.sv
// Saturating up-counter: counts cycles with inc=1 and holds at all-ones.
module sat_cnt
   import pipe_skid_reg_pkg::*;
#(
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Count up on inc, stop at the maximum value, clear on reset.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_MAX)) begin
         cnt <= cnt + CNT_ONE;
      end else begin
         cnt <= cnt;
      end
   end

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry skid buffer between pipeline stages. Head and tail storage and
// the occupancy FSM live here; outputs come straight from registers, and
// the head is kept zero whenever the buffer is empty so a bubble is a NOP.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int PC_W   = DEF_PC_W,
   parameter int INST_W = DEF_INST_W,
   parameter int SIDE_W = DEF_SIDE_W,
   parameter int CNT_W  = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PC_W-1:0]   in_pc,
   input  logic [INST_W-1:0] in_inst,
   input  logic [SIDE_W-1:0] in_side,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [PC_W-1:0]   out_pc,
   output logic [INST_W-1:0] out_inst,
   output logic [SIDE_W-1:0] out_side,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int D_W = PC_W + INST_W + SIDE_W;

   skid_state_t    state;
   skid_state_t    state_nxt;
   logic [D_W-1:0] head;
   logic [D_W-1:0] tail;
   logic [D_W-1:0] head_nxt;
   logic [D_W-1:0] tail_nxt;
   logic [D_W-1:0] in_beat;
   logic           push;
   logic           pop;
   logic           stall;

   assign in_beat = {in_pc, in_inst, in_side};
   assign push    = in_valid && in_ready;
   assign pop     = out_valid && out_ready;
   assign stall   = (out_valid && !out_ready) ? STOP : NO_STOP;

   // Head is zero while empty, so the output fields are a direct slice.
   assign out_pc   = head[D_W-1 -: PC_W];
   assign out_inst = head[SIDE_W +: INST_W];
   assign out_side = head[SIDE_W-1:0];

   // Next occupancy and storage contents; flush empties and clears everything.
   always_comb begin
      state_nxt = state;
      head_nxt  = head;
      tail_nxt  = tail;
      if (flush) begin
         state_nxt = EMPTY;
         head_nxt  = '0;
         tail_nxt  = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (push) begin
                  state_nxt = ONE;
                  head_nxt  = in_beat;
               end else begin
                  state_nxt = EMPTY;
               end
            end
            ONE: begin
               if (push && pop) begin
                  state_nxt = ONE;
                  head_nxt  = in_beat;
               end else if (push) begin
                  state_nxt = FULL;
                  tail_nxt  = in_beat;
               end else if (pop) begin
                  state_nxt = EMPTY;
                  head_nxt  = '0;
               end else begin
                  state_nxt = ONE;
               end
            end
            FULL: begin
               // in_ready is low while FULL, so only a pop can occur here.
               if (pop) begin
                  state_nxt = ONE;
                  head_nxt  = tail;
                  tail_nxt  = '0;
               end else begin
                  state_nxt = FULL;
               end
            end
            default: begin
               state_nxt = EMPTY;
               head_nxt  = '0;
               tail_nxt  = '0;
            end
         endcase
      end
   end

   // State/storage registers; handshake flags are registered from the next state.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         state     <= EMPTY;
         head      <= '0;
         tail      <= '0;
         out_valid <= 1'b0;
         in_ready  <= 1'b1;
      end else begin
         state     <= state_nxt;
         head      <= head_nxt;
         tail      <= tail_nxt;
         out_valid <= (state_nxt != EMPTY);
         in_ready  <= (state_nxt != FULL);
      end
   end

   sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .clk (clk),
      .rst (rst),
      .inc (stall),
      .cnt (stall_cnt)
   );

endmodule
